instr_fetch_unit: RTL and testbench

- Instruction-fetch front end placed directly upstream of the single-cycle datapath.
- Takes the datapath's next-instruction address and runs a read handshake with instruction memory.
- Captures the returned word and presents it as a stable, valid instruction.
- The datapath steps only on a valid instruction and acknowledges consumption, which starts the next fetch.

---
 rtl/instr_fetch_unit.sv | 133 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: read handshake with instruction memory, hold word until acked.
// Optional request timeout with sticky fault is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
   parameter int WORD_SIZE = 16,
   parameter int TIMEOUT   = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_SIZE-1:0] pc_in,
   input  logic                 instr_ack,
   output logic                 mem_read_m,
   output logic [WORD_SIZE-1:0] mem_address,
   input  logic [WORD_SIZE-1:0] mem_data,
   input  logic                 mem_input_ready,
   output logic [WORD_SIZE-1:0] instruction,
   output logic                 instr_valid,
   output logic [WORD_SIZE-1:0] num_inst,
   output logic                 fetch_fault
);

   if (TIMEOUT < 1) begin : g_bad_timeout
      $error("TIMEOUT must be at least 1");
   end

`ifdef FETCH_TIMEOUT_EN
   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_VALID,
      S_FAULT
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_VALID
   } state_t;
`endif

   state_t state_q;
   state_t state_d;

   logic   capture;
   logic   accept;

   assign capture = (state_q == S_REQ) && mem_input_ready;
   assign accept  = (state_q == S_VALID) && instr_ack;

`ifdef FETCH_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] tmo_cnt;
   logic          tmo_hit;

   assign tmo_hit = (tmo_cnt == TMO_LAST);

   // Held at zero outside S_REQ, so every entry into S_REQ starts a fresh count.
   always_ff @(posedge clk) begin
      if (reset || state_q != S_REQ) begin
         tmo_cnt <= '0;
      end else if (!mem_input_ready) begin
         tmo_cnt <= tmo_cnt + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            state_d = S_REQ;
         end
         S_REQ: begin
            // A response on the final allowed cycle still counts as a capture.
            if (mem_input_ready) begin
               state_d = S_VALID;
`ifdef FETCH_TIMEOUT_EN
            end else if (tmo_hit) begin
               state_d = S_FAULT;
`endif
            end
         end
         S_VALID: begin
            if (instr_ack) begin
               state_d = S_REQ;
            end
         end
`ifdef FETCH_TIMEOUT_EN
         S_FAULT: begin
            state_d = S_FAULT;
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_address <= '0;
         instruction <= '0;
         num_inst    <= '0;
      end else begin
         if (capture) begin
            instruction <= mem_data;
         end
         if (accept) begin
            mem_address <= pc_in;
            num_inst    <= num_inst + 1'b1;
         end
      end
   end

   assign mem_read_m  = (state_q == S_REQ);
   assign instr_valid = (state_q == S_VALID);

`ifdef FETCH_TIMEOUT_EN
   assign fetch_fault = (state_q == S_FAULT);
`else
   assign fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a transaction-level model.
// Directed phases pin reset, capture, hold, ack, stall and (with FETCH_TIMEOUT_EN) timeout.
module tb_instr_fetch_unit;

   localparam int W   = 16;
   localparam int TMO = 15;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [W-1:0] pc_in = '0;
   logic         instr_ack = 1'b0;
   logic [W-1:0] mem_data = '0;
   logic         mem_input_ready = 1'b0;
   logic         mem_read_m;
   logic [W-1:0] mem_address;
   logic [W-1:0] instruction;
   logic         instr_valid;
   logic [W-1:0] num_inst;
   logic         fetch_fault;

   instr_fetch_unit #(
      .WORD_SIZE(W),
      .TIMEOUT  (TMO)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .pc_in          (pc_in),
      .instr_ack      (instr_ack),
      .mem_read_m     (mem_read_m),
      .mem_address    (mem_address),
      .mem_data       (mem_data),
      .mem_input_ready(mem_input_ready),
      .instruction    (instruction),
      .instr_valid    (instr_valid),
      .num_inst       (num_inst),
      .fetch_fault    (fetch_fault)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   // Model: what the fetch unit is doing, as flags plus an outstanding-wait count.
   bit           m_starting = 1'b1;
   bit           m_fetching = 1'b0;
   bit           m_holding  = 1'b0;
   bit           m_faulted  = 1'b0;
   int           m_waited   = 0;
   logic [W-1:0] m_addr  = '0;
   logic [W-1:0] m_instr = '0;
   int unsigned  m_acks  = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_starting = 1'b1;
         m_fetching = 1'b0;
         m_holding  = 1'b0;
         m_faulted  = 1'b0;
         m_addr     = '0;
         m_instr    = '0;
         m_acks     = 0;
      end else if (m_starting) begin
         m_starting = 1'b0;
         m_fetching = 1'b1;
         m_waited   = 0;
      end else if (m_fetching) begin
         if (mem_input_ready) begin
            m_instr    = mem_data;
            m_fetching = 1'b0;
            m_holding  = 1'b1;
         end else begin
            m_waited++;
`ifdef FETCH_TIMEOUT_EN
            if (m_waited >= TMO) begin
               m_fetching = 1'b0;
               m_faulted  = 1'b1;
            end
`endif
         end
      end else if (m_holding && instr_ack) begin
         m_addr     = pc_in;
         m_acks     = m_acks + 1;
         m_holding  = 1'b0;
         m_fetching = 1'b1;
         m_waited   = 0;
      end
      #1;
      check("mem_read_m", W'(mem_read_m), W'(m_fetching));
      check("instr_valid", W'(instr_valid), W'(m_holding));
      check("fetch_fault", W'(fetch_fault), W'(m_faulted));
      check("mem_address", mem_address, m_addr);
      check("instruction", instruction, m_instr);
      check("num_inst", num_inst, W'(m_acks % 65536));
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      tick(2);
      check("rst_read", W'(mem_read_m), W'(0));
      check("rst_valid", W'(instr_valid), W'(0));
      check("rst_addr", mem_address, 16'h0000);
      check("rst_instr", instruction, 16'h0000);
      check("rst_num", num_inst, 16'h0000);
      check("rst_fault", W'(fetch_fault), W'(0));

      // Zero-wait memory at address 0.
      reset = 1'b0;
      mem_data = 16'h6A01;
      mem_input_ready = 1'b1;
      tick(1);
      check("first_read", W'(mem_read_m), W'(1));
      check("first_addr", mem_address, 16'h0000);
      check("first_nvalid", W'(instr_valid), W'(0));
      tick(1);
      check("first_instr", instruction, 16'h6A01);
      check("first_valid", W'(instr_valid), W'(1));
      check("first_nread", W'(mem_read_m), W'(0));

      // Hold without ack while memory lines wiggle.
      for (int i = 0; i < 5; i++) begin
         mem_data = W'($urandom);
         mem_input_ready = i[0];
         tick(1);
         check("hold_instr", instruction, 16'h6A01);
         check("hold_num", num_inst, 16'h0000);
      end

      // Ack with a stale ready on the same edge.
      pc_in = 16'h0ABC;
      instr_ack = 1'b1;
      mem_input_ready = 1'b1;
      mem_data = 16'hFFFF;
      tick(1);
      instr_ack = 1'b0;
      mem_input_ready = 1'b0;
      check("ack_addr", mem_address, 16'h0ABC);
      check("ack_read", W'(mem_read_m), W'(1));
      check("ack_nvalid", W'(instr_valid), W'(0));
      check("ack_num", num_inst, 16'h0001);
      check("ack_instr", instruction, 16'h6A01);

      // Three stall cycles then capture.
      tick(3);
      check("stall_read", W'(mem_read_m), W'(1));
      check("stall_addr", mem_address, 16'h0ABC);
      check("stall_nvalid", W'(instr_valid), W'(0));
      mem_data = 16'h1234;
      mem_input_ready = 1'b1;
      tick(1);
      mem_input_ready = 1'b0;
      check("stall_instr", instruction, 16'h1234);
      check("stall_valid", W'(instr_valid), W'(1));

      // Reset during a stalled fetch at 0x0010.
      pc_in = 16'h0010;
      instr_ack = 1'b1;
      tick(1);
      instr_ack = 1'b0;
      check("pre_rst_addr", mem_address, 16'h0010);
      tick(1);
      reset = 1'b1;
      mem_input_ready = 1'b1;
      mem_data = 16'hBEEF;
      tick(1);
      check("mid_rst_read", W'(mem_read_m), W'(0));
      check("mid_rst_addr", mem_address, 16'h0000);
      check("mid_rst_instr", instruction, 16'h0000);
      check("mid_rst_num", num_inst, 16'h0000);
      reset = 1'b0;
      tick(1);
      mem_input_ready = 1'b0;
      check("late_rdy_instr", instruction, 16'h0000);
      check("refetch_addr", mem_address, 16'h0000);
      check("refetch_read", W'(mem_read_m), W'(1));
      tick(1);
      check("late_rdy_nvalid", W'(instr_valid), W'(0));

      // Randomized traffic, occasional reset.
      for (int i = 0; i < 4000; i++) begin
         reset = ($urandom_range(0, 299) == 0);
         mem_input_ready = ($urandom_range(0, 2) != 0);
         mem_data = W'($urandom);
         instr_ack = ($urandom_range(0, 1) == 1);
         pc_in = W'($urandom);
         tick(1);
      end
      reset = 1'b0;
      instr_ack = 1'b0;
      mem_input_ready = 1'b0;

`ifdef FETCH_TIMEOUT_EN
      reset = 1'b1;
      tick(1);
      reset = 1'b0;
      tick(TMO);
      tick(5);
      check("tmo_fault", W'(fetch_fault), W'(1));
      check("tmo_nread", W'(mem_read_m), W'(0));
      check("tmo_nvalid", W'(instr_valid), W'(0));
      mem_input_ready = 1'b1;
      tick(3);
      check("tmo_sticky", W'(fetch_fault), W'(1));
      mem_input_ready = 1'b0;
      reset = 1'b1;
      tick(1);
      check("tmo_rst_clear", W'(fetch_fault), W'(0));
      reset = 1'b0;
      tick(TMO);
      mem_data = 16'h5A5A;
      mem_input_ready = 1'b1;
      tick(1);
      mem_input_ready = 1'b0;
      check("tmo_edge_instr", instruction, 16'h5A5A);
      check("tmo_edge_valid", W'(instr_valid), W'(1));
      check("tmo_edge_nfault", W'(fetch_fault), W'(0));
`endif

      tick(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
